cdb_arbiter: RTL
================

// Module: cdb_arbiter
// PURPOSE
//  Arbitrates the Common Data Bus among the functional units (ADD, MUL, LOAD). Winner's result
//  drives BCEN/BClabel/BCdata, the broadcast inputs of every reservation-station queue.
//  Round-robin grant, one broadcast per cycle, registered output.
//  A completing unit holds req_valid until it sees req_ready.
// PARAMETERS
//  NREQ  3   number of requesting functional units (2..8)
//  DW    32  broadcast data width
//  LW    4   tag (label) width; label 0 = "no tag / value ready", never broadcast
// PORTS
//  clk        in   1        clock, posedge
//  nRST       in   1        asynchronous, active-low reset
//  hold       in   1        freeze arbitration (no grants, BCEN forced 0 next cycle)
//  req_valid  in   NREQ     unit i has a result pending
//  req_label  in   NREQ*LW  tag of unit i, slice [i*LW +: LW]
//  req_data   in   NREQ*DW  result of unit i, slice [i*DW +: DW]
//  req_ready  out  NREQ     one-hot grant/ack; unit i drops or replaces its request next cycle
//  BCEN       out  1        broadcast enable (registered)
//  BClabel    out  LW       broadcast tag (registered)
//  BCdata     out  DW       broadcast value (registered)
//  err_zero   out  1        sticky: a label-0 request was granted
// BEHAVIOUR
//  - Reset (async, nRST=0): BCEN=0, BClabel=0, BCdata=0, err_zero=0, rr_ptr=0.
//  - req_ready is combinational from req_valid, rr_ptr and hold. It is 0 for all bits when hold=1.
//  - Grant search starts at index rr_ptr, rising with wrap (rr_ptr, rr_ptr+1 .. NREQ-1, 0 ..).
//    The first valid index wins. At most one req_ready bit is high.
//  - On grant to unit g at edge N:
//    - BCEN=1, BClabel=req_label[g], BCdata=req_data[g] after edge N (1-cycle latency).
//    - rr_ptr <= (g==NREQ-1) ? 0 : g+1.
//  - No grant at edge N (no valid, or hold=1): BCEN=0 after edge N; BClabel/BCdata keep their last
//    values; rr_ptr unchanged.
//  - Label 0 granted: the request is acked (req_ready=1) but not broadcast, so BCEN=0. err_zero <= 1
//    and stays set until reset. rr_ptr advances as for a normal grant.
//  - Hold asserted while BCEN=1: the current broadcast completes this cycle and is not repeated.
//    Pending requests wait unchanged.
//  - Simultaneous requests: losers stay pending. The loser nearest rr_ptr wins next cycle.
//    Starvation bound is NREQ-1 cycles without hold.
//  - Back-to-back: a unit may re-assert valid with a new tag the cycle after its ack. It then
//    competes normally (rr_ptr now points past it).
//  - Reset mid-broadcast: BCEN drops asynchronously. The in-flight result is lost; the owning unit
//    resets too.
//  - Arbiter has no storage beyond the output register. Request data must be stable while valid=1.
// CONFIGURATION
//  CDB_STATS_EN defined:
//    - Adds outputs stat_bcast[31:0] (count of cycles with BCEN=1).
//    - Adds stat_stall[31:0] (cycles with any req_valid=1 and no grant, including hold).
//    - Both reset to 0, wrap modulo 2^32, update on posedge.
//  CDB_STATS_EN undefined:
//    - Ports and counters absent. Grant and broadcast timing identical.
// TESTING
//  1 reset: nRST=0 during BCEN=1 -> BCEN=0, BClabel=0, BCdata=0, err_zero=0 immediately,
//    without a clock edge.
//  2 single: unit1 valid, label=5, data=0xDEADBEEF -> req_ready=3'b010 same cycle.
//    Next cycle BCEN=1, BClabel=5, BCdata=0xDEADBEEF. rr_ptr=2.
//  3 contention: all 3 valid continuously from reset, distinct labels 1,2,3 -> grant order 0,1,2,0,..
//    BCEN=1 every cycle.
//  4 hold: units 0 and 2 valid, hold=1 for 3 cycles -> req_ready=0, BCEN=0 during hold.
//    hold=0 -> unit 0 granted, then unit 2 next cycle.
//  5 zero label: unit2 valid, label=0 -> req_ready[2]=1, BCEN stays 0, err_zero=1 sticky.
//  6 stats (CDB_STATS_EN): scenario 4 then drain -> stat_stall=3, stat_bcast=2.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin Common Data Bus arbiter with a registered broadcast output.
// Define CDB_STATS_EN to add the stat_bcast / stat_stall counters.
module cdb_arbiter #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned DW   = 32,
    parameter int unsigned LW   = 4
) (
    input  logic               clk,
    input  logic               nRST,
    input  logic               hold,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*LW-1:0] req_label,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               BCEN,
    output logic [LW-1:0]      BClabel,
    output logic [DW-1:0]      BCdata,
`ifdef CDB_STATS_EN
    output logic [31:0]        stat_bcast,
    output logic [31:0]        stat_stall,
`endif
    output logic               err_zero
);

    localparam int unsigned PW     = $clog2(NREQ);
    localparam logic [PW:0] NREQ_W = (PW+1)'(NREQ);

    logic [PW-1:0] rr_ptr_q;
    logic [PW-1:0] rr_ptr_d;
    logic [LW-1:0] label_arr [NREQ];
    logic [DW-1:0] data_arr  [NREQ];
    logic [PW:0]   idx;
    logic [PW-1:0] win;
    logic          found;
    logic          grant;
    logic          bcast;
    logic [LW-1:0] win_label;
    logic [DW-1:0] win_data;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign label_arr[i] = req_label[i*LW +: LW];
        assign data_arr[i]  = req_data[i*DW +: DW];
    end

    // Search from rr_ptr upward with wrap; first valid index wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (idx >= NREQ_W) begin
                idx = idx - NREQ_W;
            end
            if (!found && req_valid[idx[PW-1:0]]) begin
                found = 1'b1;
                win   = idx[PW-1:0];
            end
        end
    end

    always_comb begin
        grant     = found && !hold;
        win_label = label_arr[win];
        win_data  = data_arr[win];
        // Label 0 means "value ready": acked but never put on the bus.
        bcast     = grant && (win_label != '0);
        req_ready = grant ? (NREQ'(1) << win) : '0;
        rr_ptr_d  = rr_ptr_q;
        if (grant) begin
            rr_ptr_d = ({1'b0, win} == NREQ_W - 1'b1) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            rr_ptr_q <= '0;
            BCEN     <= 1'b0;
            BClabel  <= '0;
            BCdata   <= '0;
            err_zero <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            BCEN     <= bcast;
            if (bcast) begin
                BClabel <= win_label;
                BCdata  <= win_data;
            end
            if (grant && !bcast) begin
                err_zero <= 1'b1;
            end
        end
    end

`ifdef CDB_STATS_EN
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            stat_bcast <= '0;
            stat_stall <= '0;
        end else begin
            stat_bcast <= stat_bcast + 32'(BCEN);
            stat_stall <= stat_stall + 32'((|req_valid) && !grant);
        end
    end
`endif

endmodule
